// File: rtl/cotm32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cotm32_pkg
// Description : Shared core constants and types. Holds the architectural
//               widths and the register-file writeback entry used by the
//               writeback arbiter and its long-latency buffer.
// Contents    : XLEN, NUM_REGS, AW          - datapath / register geometry
//               WB_FIFO_DEPTH               - long-latency writeback buffer depth
//               WB_STARVE_LIMIT             - lost arbitrations before ALU throttle
//               wb_entry_t                  - {rd, data} writeback record
//               is_x0()                     - true for the hard-wired zero register
// Revision    : 1.0 - initial release
// ============================================================================
package cotm32_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int AW       = $clog2(NUM_REGS);

  localparam int WB_FIFO_DEPTH   = 2;
  localparam int WB_STARVE_LIMIT = 4;

  // One pending register-file write: destination and result.
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // x0 reads as zero; writes to it are architecturally discarded.
  function automatic logic is_x0(input logic [AW-1:0] addr);
    return addr == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Small synchronous FIFO for long-latency writeback results.
//               Strict in-order, first-word-fall-through head. Readiness is
//               derived from the registered occupancy only, so o_ready never
//               depends on i_pop in the same cycle.
// Parameters  : DEPTH - number of entries (power of two, >= 2)
//               T     - entry type
// Ports       : i_clk, i_rst_n        clock, async active-low reset
//               i_push, i_data        write request / data (taken when o_ready)
//               o_ready               occupancy below DEPTH
//               i_pop                 consume head (taken when o_valid)
//               o_valid, o_head       head present / head entry
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0]
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  output logic o_ready,
  input  T     i_data,
  input  logic i_pop,
  output logic o_valid,
  output T     o_head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   c_depth = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] c_one   = PW'(1);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_ready = (r_count < c_depth);
  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rptr];

  // A push into an empty FIFO only becomes visible at the head next cycle,
  // because o_valid is taken from the registered count.
  assign w_push = i_push && o_ready;
  assign w_pop  = i_pop  && o_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: nothing reads it until the count says it is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Write-side initiator for the core register file. Merges the
//               single-cycle ALU writeback with buffered long-latency
//               (LSU / MUL-DIV) results onto one write port, keeps a
//               per-register pending-write scoreboard for hazard stalls, and
//               throttles the ALU when the buffered head starves.
// Ports       : i_clk, i_rst_n                 clock, async active-low reset
//               i_issue_valid/i_issue_rd       long-latency op issuing
//               o_issue_ready                  destination is free
//               i_alu_we/i_alu_rd/i_alu_data   ALU writeback (no backpressure)
//               o_alu_stall                    registered ALU throttle
//               i_lsu_valid/i_lsu_rd/i_lsu_data, o_lsu_ready
//                                              long-latency result handshake
//               o_rf_we/o_rf_waddr/o_rf_wdata  register-file write port
//               i_rs1_addr/i_rs2_addr          scoreboard queries
//               o_rs1_busy/o_rs2_busy          pending long-latency write
// Notes       : The buffered entry type comes from cotm32_pkg, so XLEN and
//               NUM_REGS must stay at the package values.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter  int XLEN         = cotm32_pkg::XLEN,
  parameter  int NUM_REGS     = cotm32_pkg::NUM_REGS,
  parameter  int FIFO_DEPTH   = cotm32_pkg::WB_FIFO_DEPTH,
  parameter  int STARVE_LIMIT = cotm32_pkg::WB_STARVE_LIMIT,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  // long-latency issue
  input  logic            i_issue_valid,
  input  logic [AW-1:0]   i_issue_rd,
  output logic            o_issue_ready,
  // ALU writeback
  input  logic            i_alu_we,
  input  logic [AW-1:0]   i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  output logic            o_alu_stall,
  // long-latency writeback
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic [AW-1:0]   i_lsu_rd,
  input  logic [XLEN-1:0] i_lsu_data,
  // register-file write port
  output logic            o_rf_we,
  output logic [AW-1:0]   o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata,
  // scoreboard queries
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy
);

  import cotm32_pkg::*;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] c_starve_max = SW'(STARVE_LIMIT);

  wb_entry_t           w_push_entry;
  wb_entry_t           w_head;
  logic                w_head_valid;
  logic                w_alu_win;
  logic                w_pop;
  logic                w_issue_fire;

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_next;

  logic [SW-1:0]       r_starve;
  logic [SW-1:0]       w_starve_next;
  logic                r_alu_stall;

  // --------------------------------------------------------------------------
  // Long-latency writeback buffer
  // --------------------------------------------------------------------------
  assign w_push_entry = '{rd: i_lsu_rd, data: i_lsu_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (wb_entry_t)
  ) u_wb_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_lsu_valid),
    .o_ready (o_lsu_ready),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_valid (w_head_valid),
    .o_head  (w_head)
  );

  // --------------------------------------------------------------------------
  // Arbitration: a real ALU write always wins; an ALU write to x0 is a
  // no-op and lets the buffered head through.
  // --------------------------------------------------------------------------
  assign w_alu_win = i_alu_we && !is_x0(i_alu_rd);
  assign w_pop     = w_head_valid && !w_alu_win;

  always_comb begin
    o_rf_we    = 1'b0;
    o_rf_waddr = '0;
    o_rf_wdata = '0;
    // The write enable is gated by the raw reset so nothing reaches the
    // register file while reset is held, whatever the ALU is driving.
    if (i_rst_n) begin
      if (w_alu_win) begin
        o_rf_we    = 1'b1;
        o_rf_waddr = i_alu_rd;
        o_rf_wdata = i_alu_data;
      end else if (w_head_valid) begin
        // A buffered result for x0 still drains, it just does not write.
        o_rf_we    = !is_x0(w_head.rd);
        o_rf_waddr = w_head.rd;
        o_rf_wdata = w_head.data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending-write scoreboard. Issue is refused while the bit is set, even in
  // the cycle its clear is happening, so set and clear never collide.
  // --------------------------------------------------------------------------
  assign o_issue_ready = is_x0(i_issue_rd) || !r_pending[i_issue_rd];
  assign w_issue_fire  = i_issue_valid && o_issue_ready && !is_x0(i_issue_rd);

  always_comb begin
    w_pending_next = r_pending;
    if (w_pop) begin
      w_pending_next[w_head.rd] = 1'b0;
    end
    if (w_issue_fire) begin
      w_pending_next[i_issue_rd] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  // No same-cycle bypass: the register file's write-through covers the pop.
  assign o_rs1_busy = r_pending[i_rs1_addr];
  assign o_rs2_busy = r_pending[i_rs2_addr];

  // --------------------------------------------------------------------------
  // Starvation throttle. Counts consecutive cycles the head loses to the ALU;
  // any pop or an empty buffer restarts the count. The stall flop follows the
  // next count, so it rises together with the count reaching the limit and
  // drops the cycle after the head finally drains.
  // --------------------------------------------------------------------------
  always_comb begin
    w_starve_next = '0;
    if (w_head_valid && w_alu_win) begin
      w_starve_next = (r_starve == c_starve_max) ? r_starve : r_starve + SW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve    <= '0;
      r_alu_stall <= 1'b0;
    end else begin
      r_starve    <= w_starve_next;
      r_alu_stall <= (w_starve_next == c_starve_max);
    end
  end

  assign o_alu_stall = r_alu_stall;

  // --------------------------------------------------------------------------
  // Protocol checks (ignored by synthesis)
  // --------------------------------------------------------------------------
  a_alu_while_stalled : assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !(i_alu_we && o_alu_stall));

  a_alu_waw_on_pending : assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !(i_alu_we && r_pending[i_alu_rd]));

  a_push_rd_not_pending : assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !(i_lsu_valid && o_lsu_ready && !is_x0(i_lsu_rd) && !r_pending[i_lsu_rd]));

endmodule
`default_nettype wire
